// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO slave: frame states, opcodes,
// register indices and the status-register layout.
package mdio_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ST2   = 4'd1,
    OP    = 4'd2,
    PHYAD = 4'd3,
    REGAD = 4'd4,
    TA    = 4'd5,
    RDATA = 4'd6,
    WDATA = 4'd7,
    SKIP  = 4'd8
  } mdio_state_e;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam logic [4:0] REG_CTRL   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;

  localparam logic [15:0] REG1_BASE = 16'h7849;
  localparam int          LINK_BIT  = 2;
  localparam int          AN_BIT    = 5;

  // Status register image with the live link and autoneg bits merged in.
  function automatic logic [15:0] status_word(input logic link, input logic an);
    logic [15:0] w;
    w           = REG1_BASE;
    w[LINK_BIT] = link;
    w[AN_BIT]   = an;
    return w;
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Brings MDC and MDIO into the system clock domain and flags each MDC rise
// with a single-cycle tick, keeping the sampled MDIO aligned with that tick.
module mdio_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic tick_o,
  output logic mdio_sync_o
);

  logic [SYNC_STAGES-1:0] mdc_q;
  logic [SYNC_STAGES-1:0] mdio_q;
  logic                   mdc_prev_q;

  // Synchronizer chains; MDC resets high so a held-high MDC cannot fake a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_q      <= {SYNC_STAGES{1'b1}};
      mdio_q     <= {SYNC_STAGES{1'b1}};
      mdc_prev_q <= 1'b1;
    end else begin
      mdc_q      <= {mdc_q[SYNC_STAGES-2:0], mdc_i};
      mdio_q     <= {mdio_q[SYNC_STAGES-2:0], mdio_i};
      mdc_prev_q <= mdc_q[SYNC_STAGES-1];
    end
  end

  assign tick_o      = mdc_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign mdio_sync_o = mdio_q[SYNC_STAGES-1];

endmodule

// File: rtl/mdio_phy_regfile.sv
// Clause 22 MDIO management slave with a small PHY register file. All frame
// decoding advances on synchronized MDC rising-edge ticks of the system clock.
module mdio_phy_regfile
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter int          NUM_REGS      = 32,
  parameter int          PREAMBLE_BITS = 32,
  parameter logic [15:0] REG0_INIT     = 16'h1140,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic        an_complete,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        err
);

  localparam int             CW      = (PREAMBLE_BITS > 0) ? $clog2(PREAMBLE_BITS + 1) : 1;
  localparam logic [CW-1:0]  PRE_MAX = CW'(PREAMBLE_BITS);
  localparam logic [5:0]     NREGS   = 6'(NUM_REGS);

  logic tick_s;
  logic mdio_s;

  mdio_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .mdc_i      (mdc),
    .mdio_i     (mdio_i),
    .tick_o     (tick_s),
    .mdio_sync_o(mdio_s)
  );

  mdio_state_e   state_q, state_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [4:0]    phy_q, phy_d;
  logic [4:0]    reg_q, reg_d;
  logic [15:0]   shift_q, shift_d;
  logic          oob_q, oob_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          wr_valid_q, wr_valid_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          err_q, err_d;

  logic [15:0]   regs_q [NUM_REGS];
  logic [15:0]   rd_val_s;
  logic [4:0]    reg_full_s;
  logic [15:0]   wdata_full_s;
  logic          addr_oob_s;
  logic          commit_s;
  logic          ctrl_reset_s;

  // Read value presented at the second turnaround bit.
  always_comb begin
    rd_val_s = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val_s = (reg_q == 5'(i)) ? regs_q[i] : rd_val_s;
    end
    if (oob_q) begin
      rd_val_s = 16'h0000;
    end else if (reg_q == REG_STATUS) begin
      rd_val_s = status_word(link_up, an_complete);
    end else if (reg_q == REG_CTRL) begin
      rd_val_s = {1'b0, regs_q[0][14:0]};
    end else begin
      rd_val_s = rd_val_s;
    end
  end

  // Frame decoder: next state of every frame register, evaluated per tick.
  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    phy_d        = phy_q;
    reg_d        = reg_q;
    shift_d      = shift_q;
    oob_d        = oob_q;
    mdio_o_d     = mdio_o_q;
    mdio_oe_d    = mdio_oe_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    err_d        = 1'b0;
    commit_s     = 1'b0;
    reg_full_s   = {reg_q[3:0], mdio_s};
    wdata_full_s = {shift_q[14:0], mdio_s};
    addr_oob_s   = ({1'b0, reg_full_s} >= NREGS);

    if (tick_s) begin
      case (state_q)
        IDLE: begin
          if (mdio_s) begin
            ones_d = (ones_q == PRE_MAX) ? ones_q : ones_q + CW'(1);
          end else if (ones_q == PRE_MAX) begin
            state_d = ST2;
            ones_d  = {CW{1'b0}};
          end else begin
            ones_d = {CW{1'b0}};
          end
        end
        ST2: begin
          if (mdio_s) begin
            state_d = OP;
            cnt_d   = 5'd0;
          end else begin
            state_d = IDLE;
            ones_d  = {CW{1'b0}};
          end
        end
        OP: begin
          op_d = {op_q[0], mdio_s};
          if (cnt_q == 5'd1) begin
            if (({op_q[0], mdio_s} == OP_READ) || ({op_q[0], mdio_s} == OP_WRITE)) begin
              state_d = PHYAD;
              cnt_d   = 5'd0;
            end else begin
              // 28 bits (PHYAD..data) remain in the frame.
              err_d   = 1'b1;
              state_d = SKIP;
              cnt_d   = 5'd27;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        PHYAD: begin
          phy_d = {phy_q[3:0], mdio_s};
          if (cnt_q == 5'd4) begin
            state_d = REGAD;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        REGAD: begin
          reg_d = reg_full_s;
          if (cnt_q == 5'd4) begin
            if (phy_q != PHY_ADDR) begin
              state_d = SKIP;
              cnt_d   = 5'd17;
            end else begin
              oob_d   = addr_oob_s;
              err_d   = addr_oob_s;
              state_d = TA;
              cnt_d   = 5'd0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        TA: begin
          if (cnt_q == 5'd0) begin
            cnt_d = 5'd1;
          end else if (op_q == OP_READ) begin
            mdio_oe_d = 1'b1;
            mdio_o_d  = 1'b0;
            shift_d   = rd_val_s;
            state_d   = RDATA;
            cnt_d     = 5'd0;
          end else begin
            state_d = WDATA;
            cnt_d   = 5'd0;
          end
        end
        RDATA: begin
          if (cnt_q == 5'd16) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            state_d   = IDLE;
            cnt_d     = 5'd0;
          end else begin
            mdio_o_d = shift_q[15];
            shift_d  = {shift_q[14:0], 1'b0};
            cnt_d    = cnt_q + 5'd1;
          end
        end
        WDATA: begin
          shift_d = wdata_full_s;
          if (cnt_q == 5'd15) begin
            state_d = IDLE;
            cnt_d   = 5'd0;
            if (!oob_q) begin
              commit_s   = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = reg_q;
              wr_data_d  = wdata_full_s;
            end else begin
              commit_s = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        SKIP: begin
          if (cnt_q == 5'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: begin
          state_d = IDLE;
          ones_d  = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign ctrl_reset_s = commit_s && (reg_q == REG_CTRL) && wdata_full_s[15];

  // Frame state and registered pad/event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ones_q     <= {CW{1'b0}};
      cnt_q      <= 5'd0;
      op_q       <= 2'b00;
      phy_q      <= 5'd0;
      reg_q      <= 5'd0;
      shift_q    <= 16'h0000;
      oob_q      <= 1'b0;
      mdio_o_q   <= 1'b1;
      mdio_oe_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      phy_q      <= phy_d;
      reg_q      <= reg_d;
      shift_q    <= shift_d;
      oob_q      <= oob_d;
      mdio_o_q   <= mdio_o_d;
      mdio_oe_q  <= mdio_oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
    end
  end

  // Register file; the status slot is never written since reg1 is computed live.
  always_ff @(posedge clk) begin
    if (rst || ctrl_reset_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == 0) ? REG0_INIT : 16'h0000;
      end
    end else if (commit_s) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if ((reg_q == 5'(i)) && (reg_q != REG_STATUS)) begin
          regs_q[i] <= wdata_full_s;
        end
      end
    end
  end

  assign mdio_o   = mdio_o_q;
  assign mdio_oe  = mdio_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mdio_phy_regfile.sv
// Bench for mdio_phy_regfile: acts as the MDIO master, queues the expected
// read-back bit streams and compares them against what it samples on the bus.
`timescale 1ns/1ps
module tb_mdio_phy_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_bus;
  logic        mdio_o;
  logic        mdio_oe;
  logic        link_up;
  logic        an_complete;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        err;

  logic        m_oe;
  logic        m_val;

  int          n_pass;
  int          n_total;
  logic        oe_acc;
  int          wr_cnt;
  int          err_cnt;
  logic [4:0]  wr_a;
  logic [15:0] wr_d;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  // Open-drain style bus with pull-up.
  assign mdio_bus = mdio_oe ? mdio_o : (m_oe ? m_val : 1'b1);

  mdio_phy_regfile #(
    .PHY_ADDR     (5'd1),
    .NUM_REGS     (24),
    .PREAMBLE_BITS(32),
    .REG0_INIT    (16'h1140),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mdc        (mdc),
    .mdio_i     (mdio_bus),
    .mdio_o     (mdio_o),
    .mdio_oe    (mdio_oe),
    .link_up    (link_up),
    .an_complete(an_complete),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .err        (err)
  );

  task automatic watch_clk();
    @(negedge clk);
    oe_acc = oe_acc | mdio_oe;
    if (wr_valid) begin
      wr_cnt = wr_cnt + 1;
      wr_a   = wr_addr;
      wr_d   = wr_data;
    end
    if (err) err_cnt = err_cnt + 1;
  endtask

  // One MDC period: master sets data while MDC is low, samples just before the rise.
  task automatic mdc_bit(input logic drv, input logic val, output logic seen);
    m_oe  = drv;
    m_val = val;
    for (int k = 0; k < 8; k++) watch_clk();
    seen = mdio_bus;
    mdc  = 1'b1;
    for (int k = 0; k < 8; k++) watch_clk();
    mdc = 1'b0;
  endtask

  task automatic send_header(input int pre, input logic [1:0] op,
                             input logic [4:0] phy, input logic [4:0] ra);
    logic s;
    oe_acc  = 1'b0;
    wr_cnt  = 0;
    err_cnt = 0;
    mdc_bit(1'b1, 1'b0, s);
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, 1'b0, s);
    mdc_bit(1'b1, 1'b1, s);
    mdc_bit(1'b1, op[1], s);
    mdc_bit(1'b1, op[0], s);
    for (int i = 4; i >= 0; i--) mdc_bit(1'b1, phy[i], s);
    for (int i = 4; i >= 0; i--) mdc_bit(1'b1, ra[i], s);
  endtask

  // Reads release the bus for TA + 16 data + one trailing MDC; rd[17] is the
  // bus at the TA2 rise, rd[16] the TA zero, rd[15:0] the data bits.
  task automatic do_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                          input logic [4:0] ra, input logic [15:0] wd, output logic [17:0] rd);
    logic s;
    send_header(pre, op, phy, ra);
    rd = 18'h3FFFF;
    if (op == 2'b10) begin
      for (int i = 0; i < 19; i++) begin
        mdc_bit(1'b0, 1'b1, s);
        if (i >= 1) rd[18-i] = s;
      end
    end else begin
      mdc_bit(1'b1, 1'b1, s);
      mdc_bit(1'b1, 1'b0, s);
      for (int i = 15; i >= 0; i--) mdc_bit(1'b1, wd[i], s);
    end
    m_oe = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [4:0] phy, input logic [4:0] ra,
                             input logic [17:0] ex_push);
    logic [17:0] rd;
    logic [17:0] ex;
    exp_q.push_back(ex_push);
    do_frame(32, 2'b10, phy, ra, 16'h0000, rd);
    ex = exp_q.pop_front();
    n_total++;
    if (rd !== ex) $display("FAIL %s: got %h want %h", name, rd, ex);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_total++;
    if ({mdio_oe, mdio_o, wr_valid, err} !== 4'b0100)
      $display("FAIL reset_ctl: got %b want 0100", {mdio_oe, mdio_o, wr_valid, err});
    else n_pass++;
    n_total++;
    if ({wr_addr, wr_data} !== 21'h0) $display("FAIL reset_wr: got %h want 0", {wr_addr, wr_data});
    else n_pass++;
    read_expect("reset_reg0", 5'd1, 5'd0, {2'b10, 16'h1140});
  endtask

  task automatic test_read_status();
    link_up = 1'b1; an_complete = 1'b1;
    read_expect("status_11", 5'd1, 5'd1, {2'b10, 16'h786D});
    n_total++;
    if (oe_acc !== 1'b1 || mdio_oe !== 1'b0)
      $display("FAIL status_oe: got acc=%b oe=%b want acc=1 oe=0", oe_acc, mdio_oe);
    else n_pass++;
    link_up = 1'b0;
    read_expect("status_01", 5'd1, 5'd1, {2'b10, 16'h7869});
    link_up = 1'b1; an_complete = 1'b0;
    read_expect("status_10", 5'd1, 5'd1, {2'b10, 16'h784D});
    an_complete = 1'b1;
  endtask

  task automatic test_write_read();
    logic [17:0] rd;
    do_frame(32, 2'b01, 5'd1, 5'd5, 16'hBEEF, rd);
    n_total++;
    if (wr_cnt !== 1 || wr_a !== 5'd5 || wr_d !== 16'hBEEF || oe_acc !== 1'b0)
      $display("FAIL write5: got n=%0d a=%0d d=%h oe=%b want n=1 a=5 d=beef oe=0",
               wr_cnt, wr_a, wr_d, oe_acc);
    else n_pass++;
    read_expect("read5", 5'd1, 5'd5, {2'b10, 16'hBEEF});
    do_frame(32, 2'b01, 5'd1, 5'd23, 16'h5A3C, rd);
    read_expect("read23", 5'd1, 5'd23, {2'b10, 16'h5A3C});
  endtask

  task automatic test_wrong_phy();
    read_expect("phy3_bus", 5'd3, 5'd5, 18'h3FFFF);
    n_total++;
    if (oe_acc !== 1'b0 || err_cnt !== 0)
      $display("FAIL phy3_oe: got oe=%b err=%0d want 0 0", oe_acc, err_cnt);
    else n_pass++;
    read_expect("phy1_after", 5'd1, 5'd5, {2'b10, 16'hBEEF});
  endtask

  task automatic test_preamble();
    logic [17:0] rd;
    exp_q.push_back(18'h3FFFF);
    do_frame(31, 2'b10, 5'd1, 5'd1, 16'h0000, rd);
    n_total++;
    if (rd !== exp_q.pop_front() || oe_acc !== 1'b0)
      $display("FAIL pre31: got %h oe=%b want 3ffff oe=0", rd, oe_acc);
    else n_pass++;
    read_expect("pre32", 5'd1, 5'd1, {2'b10, 16'h786D});
  endtask

  task automatic test_soft_reset();
    logic [17:0] rd;
    do_frame(32, 2'b01, 5'd1, 5'd5, 16'h1234, rd);
    read_expect("pre_sr5", 5'd1, 5'd5, {2'b10, 16'h1234});
    do_frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, rd);
    read_expect("sr_reg0", 5'd1, 5'd0, {2'b10, 16'h1140});
    read_expect("sr_reg5", 5'd1, 5'd5, {2'b10, 16'h0000});
  endtask

  task automatic test_reg1_write();
    logic [17:0] rd;
    do_frame(32, 2'b01, 5'd1, 5'd1, 16'h0000, rd);
    n_total++;
    if (wr_cnt !== 1 || wr_a !== 5'd1) $display("FAIL reg1_wv: got n=%0d a=%0d want 1 1", wr_cnt, wr_a);
    else n_pass++;
    read_expect("reg1_ro", 5'd1, 5'd1, {2'b10, 16'h786D});
  endtask

  task automatic test_errors();
    logic [17:0] rd;
    do_frame(32, 2'b11, 5'd1, 5'd5, 16'hFFFF, rd);
    n_total++;
    if (err_cnt !== 1 || wr_cnt !== 0 || oe_acc !== 1'b0)
      $display("FAIL badop: got err=%0d wr=%0d oe=%b want 1 0 0", err_cnt, wr_cnt, oe_acc);
    else n_pass++;
    read_expect("oob_read", 5'd1, 5'd30, {2'b10, 16'h0000});
    n_total++;
    if (err_cnt !== 1) $display("FAIL oob_rd_err: got %0d want 1", err_cnt);
    else n_pass++;
    do_frame(32, 2'b01, 5'd1, 5'd24, 16'hAAAA, rd);
    n_total++;
    if (err_cnt !== 1 || wr_cnt !== 0) $display("FAIL oob_wr: got err=%0d wr=%0d want 1 0", err_cnt, wr_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    logic s;
    send_header(32, 2'b10, 5'd1, 5'd1);
    for (int i = 0; i < 10; i++) mdc_bit(1'b0, 1'b1, s);
    n_total++;
    if (mdio_oe !== 1'b1) $display("FAIL mid_driving: got %b want 1", mdio_oe);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (mdio_oe !== 1'b0) $display("FAIL mid_rst_oe: got %b want 0", mdio_oe);
    else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    read_expect("after_rst", 5'd1, 5'd1, {2'b10, 16'h786D});
    read_expect("after_rst5", 5'd1, 5'd5, {2'b10, 16'h0000});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1; mdc = 1'b0; m_oe = 1'b0; m_val = 1'b1;
    link_up = 1'b1; an_complete = 1'b1;
    oe_acc = 1'b0; wr_cnt = 0; err_cnt = 0; wr_a = 5'd0; wr_d = 16'h0000;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_read_status();
    test_write_read();
    test_wrong_phy();
    test_preamble();
    test_soft_reset();
    test_reg1_write();
    test_errors();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdio_phy_regfile.md
Name: mdio_phy_regfile

Overview:
- Synthesizable IEEE 802.3 Clause 22 MDIO management slave with a parametrised PHY register file.
- Runs on the system clock. Oversamples MDC/MDIO and drives MDIO through an output-enable.
- Replaces bench-only PHY models: serves reads and writes, answers only its own PHY address, and reflects live link status.
- Instantiated opposite the MAC's MDIO master in simulation, and usable in loopback builds.

Parameters:
- PHY_ADDR, 5'd1: PHY address this slave answers.
- NUM_REGS, 32: implemented registers 0..NUM_REGS-1, range 2..32.
- PREAMBLE_BITS, 32: consecutive 1s required before ST. 0 means preamble suppression.
- REG0_INIT, 16'h1140: reset value of the control register.
- SYNC_STAGES, 2: synchronizer depth for MDC and MDIO input.

Ports:
- clk, in, 1: system clock; must be at least 4x MDC.
- rst, in, 1: synchronous, active-high reset.
- mdc, in, 1: management clock from master, asynchronous.
- mdio_i, in, 1: MDIO pad input.
- mdio_o, out, 1: MDIO drive value.
- mdio_oe, out, 1: 1 = slave drives MDIO.
- link_up, in, 1: live value of reg1 bit 2.
- an_complete, in, 1: live value of reg1 bit 5.
- wr_valid, out, 1: one-clk pulse when a write commits.
- wr_addr, out, 5: register address of the committed write.
- wr_data, out, 16: data of the committed write.
- err, out, 1: one-clk pulse on a bad opcode, or an out-of-range access to our address.

Behaviour:
- Reset: mdio_oe=0, mdio_o=1, wr_valid=0, err=0, wr_addr=0, wr_data=0. State IDLE, ones counter 0. reg0=REG0_INIT, all other writable registers 0.
- mdc and mdio_i are synchronized. An MDC rising edge is detected as a one-clk "tick". All bit sampling and all state changes happen on tick.
- mdio_o and mdio_oe are registered. They update the clk after the tick, so the master sees new data before the following MDC rise.
- IDLE:
  - mdio=1: ones counter increments, saturating at PREAMBLE_BITS.
  - mdio=0 with counter == PREAMBLE_BITS: go to ST2.
  - mdio=0 otherwise: clear the counter.
- ST2: bit must be 1, then go to OP. Otherwise clear the counter and return to IDLE.
- OP: 2 bits, MSB first. 10 = read, 01 = write. Any other value: pulse err and go to SKIP.
- PHYAD: 5 bits, MSB first.
- REGAD: 5 bits, MSB first.
- After REGAD:
  - phy_addr != PHY_ADDR: go to SKIP and never drive.
  - reg_addr >= NUM_REGS: pulse err but continue the frame. A read returns 16'h0000; a write is dropped.
- TA, read:
  - Bit 1: mdio_oe stays 0.
  - Bit 2: mdio_oe=1, mdio_o=0, and the shift register loads the read value.
- TA, write: both bits are ignored and the slave never drives.
- RDATA: 16 ticks, each presenting shift[15] and then shifting left. On the tick after the 16th bit, mdio_oe=0 and the state returns to IDLE.
- WDATA: shift in 16 bits. On the 16th bit the write commits and wr_valid pulses for one clk with wr_addr and wr_data.
- SKIP: ignore the remaining bits so a frame is always 32 bits from ST, then go to IDLE.
- Every frame end returns to IDLE with the ones counter at 0, so the next frame needs a fresh preamble.
- reg0 (control):
  - Writable.
  - Writing bit15=1 reinitialises all writable registers to reset values in the commit clk; the written data itself is discarded.
  - Bit15 always reads 0.
- reg1 (status):
  - Read-only; writes are ignored but still pulse wr_valid.
  - Read value = REG1_BASE with bit2=link_up and bit5=an_complete, sampled at TA bit 2.
- Other registers: writable, full 16 bits.
- rst mid-frame: takes priority in the same clk. mdio_oe drops immediately and any pending write is lost.
- MDC stopped mid-frame: the state holds; there is no timeout.

Decomposition:
- mdio_pkg holds:
  - state enum: IDLE, ST2, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP;
  - opcode constants OP_READ=2'b10 and OP_WRITE=2'b01;
  - register indices REG_CTRL=0 and REG_STATUS=1;
  - REG1_BASE=16'h7849 and the bit positions of link and AN-complete.
- One sub-module, mdio_edge_sync: SYNC_STAGES synchronizer for mdc and mdio_i, plus a rising-edge tick generator.

Test Plan:
- Read reg1 at PHY_ADDR=1, link_up=1, an_complete=1, 32-bit preamble -> slave drives TA 0, then returns 16'h786D MSB first; mdio_oe=0 after bit 16.
- Write 16'hBEEF to reg 5, then read reg 5 -> wr_valid pulses once with wr_addr=5 and wr_data=16'hBEEF; the read returns 16'hBEEF.
- Read with PHY address 3 -> mdio_oe stays 0 for the whole frame; the next frame to address 1 is served normally.
- Preamble of 31 ones, then a frame -> ignored, no drive. Repeating with 32 ones -> served.
- Write reg0=16'h8000 after reg5=16'h1234 -> reg0 reads 16'h1140 and reg5 reads 16'h0000.
- Assert rst at RDATA bit 8 -> mdio_oe=0 in the same clk; the next full read of reg1 completes correctly.
